coincidence_counter: RTL and testbench

- Parametrised successor to the team's 6-input, 2-bit-output channel classifier.
- Takes N_CH single-bit detector channels, synchronises them, and detects rising edges.
- Classifies each cycle's edge pattern into a 2-bit code and flags coincidences (≥ THRESH simultaneous edges).
- Counts coincidences over a programmable gate window and presents one registered count per window, for readout logic.

---
 rtl/coincidence_counter_pkg.sv | 24 ++
 rtl/coincidence_counter_popcount.sv | 17 +
 rtl/coincidence_counter.sv | 121 ++++++++++++
 tb/tb_coincidence_counter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/coincidence_counter_pkg.sv
// Shared types for the coincidence counter: edge-class codes, gate FSM
// states and the popcount-to-class mapping.
package coincidence_counter_pkg;

    localparam logic [1:0] CLS_NONE   = 2'd0;
    localparam logic [1:0] CLS_SINGLE = 2'd1;
    localparam logic [1:0] CLS_MULTI  = 2'd2;
    localparam logic [1:0] CLS_COINC  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_e;

    function automatic logic [1:0] classify(input int p, input int thresh);
        logic [1:0] c;
        if (p == 0)           c = CLS_NONE;
        else if (p == 1)      c = CLS_SINGLE;
        else if (p < thresh)  c = CLS_MULTI;
        else                  c = CLS_COINC;
        return c;
    endfunction

endpackage

// File: rtl/coincidence_counter_popcount.sv
// Combinational population count of an N-bit vector.
module popcount_n #(
    parameter int N = 6,
    localparam int W = $clog2(N + 1)
) (
    input  logic [N-1:0] bits_i,
    output logic [W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/coincidence_counter.sv
// Synchronises detector channels, classifies per-cycle rising-edge patterns
// and counts coincidences over back-to-back gate windows.
module coincidence_counter
    import coincidence_counter_pkg::*;
#(
    parameter int N_CH        = 6,
    parameter int THRESH      = 5,
    parameter int GATE_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [N_CH-1:0]  ch,
    output logic [1:0]       cls,
    output logic             coinc_pulse,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow
);

    localparam int PW = $clog2(N_CH + 1);
    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0]    T_LAST  = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0]    TH      = PW'(THRESH);

    logic [N_CH-1:0]  s1_q, s2_q, s3_q;
    logic [N_CH-1:0]  rise;
    logic [PW-1:0]    p;
    logic [1:0]       cls_q;
    logic             coinc_q;
    state_e           state_q;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             ovf_q;
    logic             ovf_hit;

    assign rise = s2_q & ~s3_q;

    popcount_n #(.N(N_CH)) u_pop (
        .bits_i (rise),
        .cnt_o  (p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            cls_q   <= CLS_NONE;
            coinc_q <= 1'b0;
        end else begin
            s1_q    <= ch;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            cls_q   <= classify(32'(p), THRESH);
            coinc_q <= (p >= TH);
        end
    end

    // Saturating accumulate; an increment attempted at the ceiling is sticky.
    assign ovf_hit = coinc_q && (acc_q == CNT_MAX);
    assign acc_d   = (coinc_q && !ovf_hit) ? acc_q + CNT_W'(1) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            timer_q <= T_LAST;
            acc_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= GATE;
                        timer_q <= T_LAST;
                        acc_q   <= '0;
                    end
                end
                GATE: begin
                    if (ovf_hit) ovf_q <= 1'b1;
                    if (timer_q == '0) begin
                        count_q <= acc_d;
                        valid_q <= 1'b1;
                        acc_q   <= '0;
                        timer_q <= T_LAST;
                        if (!en) state_q <= IDLE;
                    end else if (!en) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                    end else begin
                        acc_q   <= acc_d;
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cls         = cls_q;
    assign coinc_pulse = coinc_q;
    assign count       = count_q;
    assign count_valid = valid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_coincidence_counter.sv
// Directed and random checks of coincidence_counter against an event-level model.
module tb_coincidence_counter;

    localparam int NC   = 6;
    localparam int TH   = 5;
    localparam int GC   = 16;
    localparam int MAXA = 255;
    localparam int MAXB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic [NC-1:0] ch = '0;

    logic [1:0] cls_a, cls_b;
    logic coinc_a, coinc_b, valid_a, valid_b, ovf_a, ovf_b;
    logic [7:0] count_a;
    logic [1:0] count_b;

    coincidence_counter #(.N_CH(NC), .THRESH(TH), .GATE_CYCLES(GC), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .ch(ch),
        .cls(cls_a), .coinc_pulse(coinc_a), .count(count_a),
        .count_valid(valid_a), .overflow(ovf_a)
    );

    coincidence_counter #(.N_CH(NC), .THRESH(TH), .GATE_CYCLES(GC), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .ch(ch),
        .cls(cls_b), .coinc_pulse(coinc_b), .count(count_b),
        .count_valid(valid_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // Reference model state: channel history plus window bookkeeping.
    logic [NC-1:0] hq [3];
    int e_cls, e_coinc, e_valid;
    int m_cnt_a, m_cnt_b, m_ovf_a, m_ovf_b;
    bit act;
    int pos, n;
    int total = 0;
    int bad = 0;
    int last_a, last_b, nv, first_idx, npulse, vidx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hq[i] = '0;
        e_cls = 0; e_coinc = 0; e_valid = 0;
        m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0;
        act = 0; pos = 0; n = 0;
    endtask

    task automatic model_tick();
        int cp, p;
        logic [NC-1:0] r;
        cp = e_coinc;
        r = hq[1] & ~hq[2];
        p = $countones(r);
        if (p == 0) e_cls = 0;
        else if (p == 1) e_cls = 1;
        else if (p < TH) e_cls = 2;
        else e_cls = 3;
        e_coinc = (p >= TH) ? 1 : 0;
        hq[2] = hq[1]; hq[1] = hq[0]; hq[0] = ch;
        e_valid = 0;
        if (clear) begin
            act = 0; m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0;
        end else if (!act) begin
            if (en) begin act = 1; pos = 0; n = 0; end
        end else begin
            n += cp;
            if (n > MAXA) m_ovf_a = 1;
            if (n > MAXB) m_ovf_b = 1;
            if (pos == GC - 1) begin
                m_cnt_a = (n > MAXA) ? MAXA : n;
                m_cnt_b = (n > MAXB) ? MAXB : n;
                e_valid = 1; n = 0; pos = 0; act = en;
            end else if (!en) begin
                act = 0;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic compare();
        chk("cls_a", 32'(cls_a), e_cls);
        chk("coinc_a", 32'(coinc_a), e_coinc);
        chk("count_a", 32'(count_a), m_cnt_a);
        chk("valid_a", 32'(valid_a), e_valid);
        chk("ovf_a", 32'(ovf_a), m_ovf_a);
        chk("cls_b", 32'(cls_b), e_cls);
        chk("coinc_b", 32'(coinc_b), e_coinc);
        chk("count_b", 32'(count_b), m_cnt_b);
        chk("valid_b", 32'(valid_b), e_valid);
        chk("ovf_b", 32'(ovf_b), m_ovf_b);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_tick();
        @(negedge clk);
        compare();
        if (valid_a) begin last_a = 32'(count_a); nv++; end
        if (valid_b) last_b = 32'(count_b);
    endtask

    initial begin
        model_reset();
        last_a = -1; last_b = -1; nv = 0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();

        // Edge classification and latency
        ch = 6'b011111; first_idx = -1; npulse = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (coinc_a) begin
                npulse++;
                if (first_idx < 0) first_idx = i;
            end
        end
        chk("edge_lat", first_idx, 2);
        chk("edge_once", npulse, 1);
        ch = '0; repeat (4) step();
        ch = 6'b110000; repeat (4) step();
        ch = '0; repeat (3) step();
        ch = 6'b000001; repeat (4) step();
        ch = '0; repeat (3) step();

        // Two back-to-back windows: 3 coincidences (one on last cycle), then 0
        nv = 0;
        for (int i = 0; i < 36; i++) begin
            en = (i < 32);
            ch = (i == 0 || i == 1 || i == 4 || i == 5 || (i >= 13 && i < 20)) ? 6'h3F : 6'h00;
            step();
            if (i == 16) chk("win1_cnt", 32'(count_a), 3);
            if (i == 16) chk("win1_valid", 32'(valid_a), 1);
            if (i == 32) chk("win2_cnt", 32'(count_a), 0);
            if (i == 32) chk("win2_valid", 32'(valid_a), 1);
        end
        chk("win_nvalid", nv, 2);

        // Saturation in the 2-bit instance
        en = 1'b0; ch = '0;
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            en = (i < 16);
            ch = (i < 14 && i % 2 == 0) ? 6'h3F : 6'h00;
            step();
        end
        chk("sat_cnt_a", last_a, 7);
        chk("sat_cnt_b", last_b, 3);
        chk("sat_ovf_b", 32'(ovf_b), 1);
        chk("sat_ovf_a", 32'(ovf_a), 0);
        ch = '0;
        for (int i = 0; i < 20; i++) begin
            en = (i < 16);
            step();
        end
        chk("sticky_cnt_b", last_b, 0);
        chk("sticky_ovf_b", 32'(ovf_b), 1);

        // Full window with 2, then an aborted window
        for (int i = 0; i < 20; i++) begin
            en = (i < 16);
            ch = (i == 0 || i == 2) ? 6'h3F : 6'h00;
            step();
        end
        chk("pre_abort_cnt", 32'(count_a), 2);
        nv = 0;
        for (int i = 0; i < 24; i++) begin
            en = (i < 8);
            ch = (i == 0 || i == 2) ? 6'h3F : 6'h00;
            step();
        end
        chk("abort_novalid", nv, 0);
        chk("abort_keep", 32'(count_a), 2);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_cnt", 32'(count_a), 0);
        chk("clr_ovf_b", 32'(ovf_b), 0);
        vidx = -1;
        for (int i = 0; i < 20; i++) begin
            en = (i < 16);
            ch = (i == 3) ? 6'h3F : 6'h00;
            step();
            if (valid_a && vidx < 0) vidx = i;
        end
        chk("fresh_idx", vidx, 16);
        chk("fresh_cnt", last_a, 1);

        // Asynchronous reset mid-cycle with activity
        en = 1'b1; ch = 6'h3F; step();
        ch = '0; step();
        ch = 6'h3F; step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cls", 32'(cls_a), 0);
        chk("rst_coinc", 32'(coinc_a), 0);
        chk("rst_count", 32'(count_a), 0);
        chk("rst_valid", 32'(valid_a), 0);
        chk("rst_ovf_b", 32'(ovf_b), 0);
        model_reset();
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: ch = 6'h3F;
                1: ch = 6'h00;
                default: ch = NC'($urandom);
            endcase
            en = ($urandom_range(0, 39) != 0);
            clear = ($urandom_range(0, 199) == 0);
            step();
        end
        clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
